// File: rtl/display_pkg.sv
// Shared display definitions: arbiter state encoding and the blank-screen
// patterns also used by the matrix and seven-segment drivers.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam logic [127:0] BLANK_MATRIX  = 128'h0;
  localparam logic [31:0]  BLANK_NUMBERS = 32'hFFFF_FFFF;

endpackage

// File: rtl/prio_pick.sv
// Combinational rotating-priority pick: the first set bit of req found when
// searching upward (with wrap) from index start.
module prio_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    j     = 0;
    valid = |req;
    idx   = '0;
    // Walk from the farthest position back to start so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (req[j]) idx = IW'(j);
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Display resource arbiter: fixed priority with minimum hold, preemption and a
// blanking gap between owners. Define DISPLAY_ARB_RR_EN for round-robin slicing.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MIN_HOLD  = 1000,
  parameter int BLANK_CYC = 2,
  parameter int CW        = 10,
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*128-1:0] matrix_in,
  input  logic [NREQ*32-1:0]  numbers_in,
  input  logic [NREQ-1:0]     beep_in,
  output logic [NREQ-1:0]     grant,
  output logic [IW-1:0]       owner,
  output logic                busy,
  output logic [127:0]        matrixData,
  output logic [31:0]         numbersData,
  output logic                beep
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  state_t          state_reg;
  logic [BW-1:0]   blank_reg;
  logic [CW-1:0]   hold_reg;
  logic [CW-1:0]   hold_next;
  logic [IW-1:0]   start;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] own_mask;
  logic [NREQ-1:0] pick_mask;
  logic [NREQ-1:0] rival_mask;
  logic [127:0]    matrix_slice  [NREQ];
  logic [31:0]     numbers_slice [NREQ];
  logic            owner_drop;
  logic            preempt;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign matrix_slice[gi]  = matrix_in[128*gi +: 128];
      assign numbers_slice[gi] = numbers_in[32*gi +: 32];
      assign own_mask[gi]      = (int'(owner) == gi);
      assign pick_mask[gi]     = (int'(pick_idx) == gi);
`ifdef DISPLAY_ARB_RR_EN
      assign rival_mask[gi]    = (int'(owner) != gi);
`else
      assign rival_mask[gi]    = (gi < int'(owner));
`endif
    end
  endgenerate

`ifdef DISPLAY_ARB_RR_EN
  logic [IW-1:0] last_reg;
  assign start = (int'(last_reg) == NREQ - 1) ? '0 : last_reg + 1'b1;
`else
  assign start = '0;
`endif

  prio_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .start (start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // hold_next is the hold count this edge completes, so an owner keeps the
  // grant for exactly MIN_HOLD cycles before a rival can take over.
  assign hold_next  = (hold_reg == CW'(MIN_HOLD)) ? hold_reg : hold_reg + 1'b1;
  assign owner_drop = ~|(req & own_mask);
  assign preempt    = (hold_next == CW'(MIN_HOLD)) && (|(req & rival_mask));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant       <= '0;
      owner       <= '0;
      busy        <= 1'b0;
      matrixData  <= BLANK_MATRIX;
      numbersData <= BLANK_NUMBERS;
      beep        <= 1'b0;
      blank_reg   <= '0;
      hold_reg    <= '0;
`ifdef DISPLAY_ARB_RR_EN
      last_reg    <= IW'(NREQ - 1);
`endif
    end else begin
      matrixData  <= BLANK_MATRIX;
      numbersData <= BLANK_NUMBERS;
      beep        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            blank_reg <= '0;
            busy      <= 1'b1;
            state_reg <= BLANK;
          end
        end
        BLANK: begin
          if (blank_reg == BW'(BLANK_CYC - 1)) begin
            if (pick_valid) begin
              owner     <= pick_idx;
              hold_reg  <= '0;
              grant     <= pick_mask;
              state_reg <= GRANT;
`ifdef DISPLAY_ARB_RR_EN
              last_reg  <= pick_idx;
`endif
            end else begin
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end else begin
            blank_reg <= blank_reg + 1'b1;
          end
        end
        GRANT: begin
          hold_reg <= hold_next;
          if (owner_drop || preempt) begin
            grant     <= '0;
            blank_reg <= '0;
            state_reg <= BLANK;
          end else begin
            matrixData  <= matrix_slice[owner];
            numbersData <= numbers_slice[owner];
            beep        <= beep_in[owner];
          end
        end
        default: begin
          grant     <= '0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (fixed priority by default, round-robin
// slicing when DISPLAY_ARB_RR_EN is defined).
module tb_display_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [511:0] matrix_in;
  logic [127:0] numbers_in;
  logic [3:0]   beep_in;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic         busy;
  logic [127:0] matrixData;
  logic [31:0]  numbersData;
  logic         beep;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  display_arbiter #(.NREQ(4), .MIN_HOLD(1000), .BLANK_CYC(2), .CW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .matrix_in   (matrix_in),
    .numbers_in  (numbers_in),
    .beep_in     (beep_in),
    .grant       (grant),
    .owner       (owner),
    .busy        (busy),
    .matrixData  (matrixData),
    .numbersData (numbersData),
    .beep        (beep)
  );

  function automatic logic [127:0] mat(int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  function automatic logic [31:0] num(int i);
    return 32'h1234_5670 + 32'(i);
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_blank(string tag);
    chk({tag, ".grant"},   128'(grant), 128'(0));
    chk({tag, ".matrix"},  matrixData, 128'h0);
    chk({tag, ".numbers"}, 128'(numbersData), 128'hFFFF_FFFF);
    chk({tag, ".beep"},    128'(beep), 128'(0));
  endtask

  task automatic chk_reset(string tag);
    chk_blank(tag);
    chk({tag, ".busy"},  128'(busy), 128'(0));
    chk({tag, ".owner"}, 128'(owner), 128'(0));
  endtask

  task automatic chk_data(string tag, int i, logic b);
    chk({tag, ".matrix"},  matrixData, mat(i));
    chk({tag, ".numbers"}, 128'(numbersData), 128'(num(i)));
    chk({tag, ".beep"},    128'(beep), 128'(b));
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b0000;
    beep_in = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      matrix_in[128*i +: 128] = mat(i);
      numbers_in[32*i +: 32]  = num(i);
    end
    tick(3);
    chk_reset("reset");
    rst = 1'b0;
    tick(10);
    chk_reset("idle_no_req");

`ifdef DISPLAY_ARB_RR_EN
    req = 4'b1111;
    tick(3);
    for (int k = 0; k < 5; k++) begin
      $display("[TB] rr slot %0d expect owner %0d", k, k % 4);
      chk("rr.grant_start", 128'(grant), 128'(4'b0001 << (k % 4)));
      chk("rr.owner",       128'(owner), 128'(k % 4));
      tick(999);
      chk("rr.grant_end",   128'(grant), 128'(4'b0001 << (k % 4)));
      tick(1);
      chk("rr.gap1",        128'(grant), 128'(0));
      tick(1);
      chk("rr.gap2",        128'(grant), 128'(0));
      tick(1);
    end
`else
    // Single request from idle: busy next cycle, grant after the blank gap.
    req = 4'b0100;
    tick(1);
    $display("[TB] req=0100 from idle");
    chk("t2.busy",  128'(busy),  128'(1));
    chk("t2.owner", 128'(owner), 128'(2));
    chk_blank("t2.blank0");
    tick(1);
    chk_blank("t2.blank1");
    tick(1);
    chk("t2.grant", 128'(grant), 128'(4'b0100));
    chk("t2.matrix_lag", matrixData, 128'h0);
    tick(1);
    chk_data("t2.data", 2, 1'b1);

    // Higher priority arrives at hold 300; no switch before hold 1000.
    tick(297);
    req = 4'b0101;
    $display("[TB] req[0] raised during hold of owner 2");
    tick(701);
    chk("t3.still_held", 128'(grant), 128'(4'b0100));
    chk_data("t3.still_data", 2, 1'b1);
    tick(1);
    chk_blank("t3.gap1");
    chk("t3.busy", 128'(busy), 128'(1));
    tick(1);
    chk_blank("t3.gap2");
    tick(1);
    chk("t3.grant", 128'(grant), 128'(4'b0001));
    chk("t3.owner", 128'(owner), 128'(0));
    tick(1);
    chk_data("t3.data", 0, 1'b1);

    // Lower-priority requests never preempt, even after the hold saturates.
    req = 4'b0011;
    tick(1100);
    $display("[TB] lower-priority req for 1100 cycles");
    chk("t4.no_preempt", 128'(grant), 128'(4'b0001));

    // Owner 0 drops while 1 and 3 request.
    req = 4'b1010;
    tick(1);
    $display("[TB] owner 0 drops with req=1010");
    chk_blank("t5.gap1");
    tick(1);
    chk_blank("t5.gap2");
    tick(1);
    chk("t5.grant", 128'(grant), 128'(4'b0010));
    chk("t5.owner", 128'(owner), 128'(1));
    tick(1);
    chk_data("t5.data", 1, 1'b1);

    // req[2] high in the gap but gone at the decision cycle.
    req = 4'b1100;
    tick(1);
    $display("[TB] req[2] withdrawn before decision");
    chk_blank("t6.gap1");
    req = 4'b1000;
    tick(2);
    chk("t6.grant", 128'(grant), 128'(4'b1000));
    tick(1);
    chk_data("t6.data", 3, 1'b0);

    // Reset mid-GRANT.
    rst = 1'b1;
    tick(1);
    $display("[TB] reset mid-grant");
    chk_reset("t7.rst_grant");
    rst = 1'b0;
    req = 4'b0001;
    tick(2);
    chk("t7.pre_grant", 128'(grant), 128'(0));
    tick(1);
    chk("t7.regrant", 128'(grant), 128'(4'b0001));

    // Reset mid-BLANK.
    req = 4'b0000;
    tick(1);
    chk("t8.blank_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    req = 4'b0001;
    tick(1);
    $display("[TB] reset mid-blank");
    chk_reset("t8.rst_blank");
    rst = 1'b0;
    tick(2);
    chk("t8.pre_grant", 128'(grant), 128'(0));
    tick(1);
    chk("t8.regrant", 128'(grant), 128'(4'b0001));

    // All requests gone: back to idle after the gap.
    req = 4'b0000;
    tick(3);
    $display("[TB] all requests released");
    chk_reset("t9.idle");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
